// File: rtl/aura_audio_pkg.sv
// rtl/aura_audio_pkg.sv - shared audio constants and I2S decoder state type
// Contents:
//   DATA_W_DEFAULT : default sample width per channel
//   i2s_state_t    : decoder slot state (HUNT, LEFT, RIGHT)
package aura_audio_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

endpackage

// File: rtl/i2s_decoder_if.sv
// rtl/i2s_decoder_if.sv - I2S serial input and decoded sample bundle
// Signals:
//   bck, lrck, data  : serial I2S lines (source -> decoder)
//   l_chan, r_chan   : decoded signed samples (decoder -> sink)
//   valid, locked    : new-pair pulse and frame-lock status (decoder -> sink)
// Modports:
//   master : drives the serial lines, observes decoded results
//   slave  : decoder view
interface i2s_decoder_if
  import aura_audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic                     bck;
  logic                     lrck;
  logic                     data;
  logic signed [DATA_W-1:0] l_chan;
  logic signed [DATA_W-1:0] r_chan;
  logic                     valid;
  logic                     locked;

  modport master (
    output bck, lrck, data,
    input  l_chan, r_chan, valid, locked
  );

  modport slave (
    input  bck, lrck, data,
    output l_chan, r_chan, valid, locked
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - multi-flop synchronizer with rising-edge detect
// Parameters:
//   STAGES : synchronizer depth (2 or more)
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized level
//   rise     : one-clk pulse when q goes 0->1
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              q_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      q_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      q_prev <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~q_prev;

endmodule

// File: rtl/i2s_decoder.sv
// rtl/i2s_decoder.sv - I2S receiver: serial L/R slots to parallel signed samples
// Optional feature macro: AURA_I2S_LOSS_DETECT_EN (BCK loss timeout -> HUNT, zero outputs)
// Parameters:
//   DATA_W         : sample width per channel
//   SYNC_STAGES    : synchronizer flops per I2S input
//   TIMEOUT_CYCLES : clk cycles without a BCK rise treated as signal loss
// Ports:
//   clk, rst                          : system clock, synchronous active-high reset
//   i2s_bck_i, i2s_lrck_i, i2s_data_i : asynchronous I2S lines (LRCK low = left)
//   l_chan_o, r_chan_o                : decoded signed samples
//   valid_o                           : one-clk pulse per new left/right pair
//   locked_o                          : frames decoding continuously
module i2s_decoder
  import aura_audio_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i2s_bck_i,
  input  logic                     i2s_lrck_i,
  input  logic                     i2s_data_i,
  output logic signed [DATA_W-1:0] l_chan_o,
  output logic signed [DATA_W-1:0] r_chan_o,
  output logic                     valid_o,
  output logic                     locked_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic bck_rise;
  logic lrck_s;
  logic data_s;
  logic bck_level_unused;
  logic lrck_rise_unused;
  logic data_rise_unused;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bck (
    .clk (clk), .rst (rst), .d (i2s_bck_i),
    .q (bck_level_unused), .rise (bck_rise)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk (clk), .rst (rst), .d (i2s_lrck_i),
    .q (lrck_s), .rise (lrck_rise_unused)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk (clk), .rst (rst), .d (i2s_data_i),
    .q (data_s), .rise (data_rise_unused)
  );

  i2s_state_t        state;
  logic              lrck_prev;   // LRCK captured at the previous BCK rise
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] hold_l;
  logic [CNT_W-1:0]  bit_cnt;
  logic              valid_pend;  // outputs updated this cycle, pulse valid_o next

  // Bits are shifted in right-aligned; a short slot is moved up so its MSB
  // lands on bit DATA_W-1 with zeros below. A shift of DATA_W yields zero.
  function automatic logic [DATA_W-1:0] justify(input logic [DATA_W-1:0] v,
                                                input logic [CNT_W-1:0]  n);
    return v << (DATA_W - int'(n));
  endfunction

`ifdef AURA_I2S_LOSS_DETECT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      lrck_prev  <= 1'b0;
      shift_reg  <= '0;
      hold_l     <= '0;
      bit_cnt    <= '0;
      valid_pend <= 1'b0;
      l_chan_o   <= '0;
      r_chan_o   <= '0;
      valid_o    <= 1'b0;
      locked_o   <= 1'b0;
`ifdef AURA_I2S_LOSS_DETECT_EN
      to_cnt     <= '0;
`endif
    end else begin
      valid_o    <= valid_pend;
      valid_pend <= 1'b0;
      if (valid_pend) begin
        locked_o <= 1'b1;
      end

      if (bck_rise) begin
        lrck_prev <= lrck_s;
        if (lrck_s != lrck_prev) begin
          // Slot boundary: this rise's data bit closes the previous slot.
          shift_reg <= '0;
          bit_cnt   <= '0;
          unique case (state)
            HUNT: begin
              if (!lrck_s) begin
                state <= LEFT;
              end
            end
            LEFT: begin
              state  <= RIGHT;
              hold_l <= justify(shift_reg, bit_cnt);
            end
            RIGHT: begin
              state      <= LEFT;
              l_chan_o   <= hold_l;
              r_chan_o   <= justify(shift_reg, bit_cnt);
              valid_pend <= 1'b1;
            end
            default: state <= HUNT;
          endcase
        end else if (bit_cnt != CNT_W'(DATA_W)) begin
          shift_reg <= {shift_reg[DATA_W-2:0], data_s};
          bit_cnt   <= bit_cnt + 1'b1;
        end
      end

`ifdef AURA_I2S_LOSS_DETECT_EN
      // Counter saturates at TIMEOUT_CYCLES so the loss action fires once.
      if (bck_rise) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state      <= HUNT;
          locked_o   <= 1'b0;
          l_chan_o   <= '0;
          r_chan_o   <= '0;
          valid_pend <= 1'b0;
          valid_o    <= 1'b0;
          shift_reg  <= '0;
          bit_cnt    <= '0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2s_decoder.sv
// tb/tb_i2s_decoder.sv - self-checking bench for i2s_decoder
module tb_i2s_decoder;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_decoder_if #(.DATA_W(DW)) bus ();

  i2s_decoder #(
    .DATA_W         (DW),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i2s_bck_i  (bus.bck),
    .i2s_lrck_i (bus.lrck),
    .i2s_data_i (bus.data),
    .l_chan_o   (bus.l_chan),
    .r_chan_o   (bus.r_chan),
    .valid_o    (bus.valid),
    .locked_o   (bus.locked)
  );

  typedef struct {
    logic        lr;
    logic [31:0] word;
    int          width;
  } slot_t;

  typedef struct {
    logic [31:0] l;
    int          lw;
    logic [31:0] r;
    int          rw;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          half   = 4;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  slot_t       slots[$];
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: collect every decoded pair, check pulse shape and lock.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      got_q.push_back({bus.l_chan, bus.r_chan});
      check("valid_one_cycle", 32'(prev_valid), 32'd0);
      check("locked_at_pulse", 32'(bus.locked), 32'd1);
    end
    prev_valid = bus.valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: left-justify a width-bit word into DW bits.
  function automatic logic [15:0] fit(input logic [31:0] w, input int width);
    logic [63:0] v;
    v = 64'(w) & ((64'd1 << width) - 64'd1);
    if (width >= DW) return 16'(v >> (width - DW));
    else             return 16'(v << (DW - width));
  endfunction

  // Reference: a full left slot yields a pair when a right slot came before it
  // (inside this stream) and a full right slot follows; the stream is always
  // closed with a left boundary.
  task automatic build_expected(input logic part_lr, input int part_bits);
    for (int i = 0; i < slots.size(); i++) begin
      if (slots[i].lr == 1'b0 && i + 1 < slots.size() && slots[i+1].lr == 1'b1) begin
        if ((i > 0 && slots[i-1].lr == 1'b1) || (i == 0 && part_bits > 0 && part_lr == 1'b1))
          exp_q.push_back({fit(slots[i].word, slots[i].width),
                           fit(slots[i+1].word, slots[i+1].width)});
      end
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    @(posedge clk); #1;
    bus.bck  = 1'b0;
    bus.lrck = lr;
    bus.data = d;
    repeat (half) @(posedge clk);
    #1;
    bus.bck = 1'b1;
    repeat (half - 1) @(posedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [31:0] word, input int width);
    send_bit(lr, 1'($urandom));
    for (int b = width - 1; b >= 0; b--) send_bit(lr, word[b]);
  endtask

  task automatic run_stream(input logic part_lr, input int part_bits);
    for (int i = 0; i < part_bits; i++) send_bit(part_lr, 1'($urandom));
    foreach (slots[i]) send_slot(slots[i].lr, slots[i].word, slots[i].width);
    send_bit(1'b0, 1'($urandom));
    repeat (12) @(posedge clk);
  endtask

  task automatic compare_pairs(input string tag);
    int n;
    check({tag, "_pulse_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_l"}, 32'(got_q[i][31:16]), 32'(exp_q[i][31:16]));
      check({tag, "_r"}, 32'(got_q[i][15:0]),  32'(exp_q[i][15:0]));
    end
    got_q.delete();
    exp_q.delete();
    slots.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] l, input logic [15:0] r,
                               input logic lk);
    @(negedge clk);
    check({tag, "_l"},      32'($unsigned(bus.l_chan)), 32'(l));
    check({tag, "_r"},      32'($unsigned(bus.r_chan)), 32'(r));
    check({tag, "_valid"},  32'(bus.valid),             32'd0);
    check({tag, "_locked"}, 32'(bus.locked),            32'(lk));
  endtask

  vec_t tbl[6];
  int   widths[6] = '{8, 12, 16, 20, 24, 32};

  initial begin
    bus.bck  = 1'b0;
    bus.lrck = 1'b0;
    bus.data = 1'b0;

    tbl[0] = '{32'h1234,     16, 32'hABCD,     16, 16'h1234, 16'hABCD};
    tbl[1] = '{32'h7FFF00,   24, 32'h800001,   24, 16'h7FFF, 16'h8000};
    tbl[2] = '{32'h5555,     16, 32'hABC,      12, 16'h5555, 16'hABC0};
    tbl[3] = '{32'h0000,     16, 32'hFFFF,     16, 16'h0000, 16'hFFFF};
    tbl[4] = '{32'h8000,     16, 32'h7FFF,     16, 16'h8000, 16'h7FFF};
    tbl[5] = '{32'h81,        8, 32'hDEADBEEF, 32, 16'h8100, 16'hDEAD};

    // Reset state
    repeat (3) @(posedge clk);
    check_outputs("reset", 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Table vectors, BCK = clk/8, stream begins mid-right-slot
    half = 4;
    foreach (tbl[i]) begin
      slots.push_back('{1'b0, tbl[i].l, tbl[i].lw});
      slots.push_back('{1'b1, tbl[i].r, tbl[i].rw});
      exp_q.push_back({tbl[i].exp_l, tbl[i].exp_r});
    end
    run_stream(1'b1, 7);
    compare_pairs("table");
    check_outputs("table_end", 16'h8100, 16'hDEAD, 1'b1);

    // Reset for one cycle in the middle of a left slot
    send_bit(1'b0, 1'b1);
    for (int b = 0; b < 8; b++) send_bit(1'b0, 1'b1);
    pulse_reset();
    check_outputs("mid_reset", 16'h0, 16'h0, 1'b0);
    slots.push_back('{1'b1, 32'h1111, 16});
    slots.push_back('{1'b0, 32'h5A5A, 16});
    slots.push_back('{1'b1, 32'hC3C3, 16});
    build_expected(1'b0, 8);
    run_stream(1'b0, 8);
    compare_pairs("after_reset");

    // BCK stops
`ifdef AURA_I2S_LOSS_DETECT_EN
    repeat (1100) @(posedge clk);
    check_outputs("bck_loss", 16'h0, 16'h0, 1'b0);
`else
    repeat (5000) @(posedge clk);
    check_outputs("bck_stop", 16'h5A5A, 16'hC3C3, 1'b1);
`endif
    compare_pairs("stop");

    // Randomized streams against the reference
    for (int round = 0; round < 2; round++) begin
      logic pl;
      int   pb;
      pulse_reset();
      half = $urandom_range(2, 6);
      pl   = 1'($urandom);
      pb   = $urandom_range(0, 10);
      for (int f = 0; f < 16; f++) begin
        slots.push_back('{~pl, $urandom, widths[$urandom_range(0, 5)]});
        slots.push_back('{pl,  $urandom, widths[$urandom_range(0, 5)]});
      end
      build_expected(pl, pb);
      run_stream(pl, pb);
      compare_pairs("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_decoder.md
I2S_DECODER -- requirements
Module: i2s_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width per channel.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per I2S input.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, clk cycles without a BCK rise that count as signal loss.
REQ-004 SHALL have port clk, input, 1, system clock (25 MHz); sole clock.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port i2s_bck_i, input, 1, asynchronous bit clock (VERA VAUDIO_BCK).
REQ-007 SHALL have port i2s_lrck_i, input, 1, asynchronous word select; low = left slot.
REQ-008 SHALL have port i2s_data_i, input, 1, asynchronous serial data, MSB first.
REQ-009 SHALL have port l_chan_o, output, DATA_W, signed left sample.
REQ-010 SHALL have port r_chan_o, output, DATA_W, signed right sample.
REQ-011 SHALL have port valid_o, output, 1, one-clk pulse when a new left/right pair is presented.
REQ-012 SHALL have port locked_o, output, 1, high while frames decode continuously.

Function
REQ-013 SHALL pass each I2S input through SYNC_STAGES flops before use; BCK rise = synchronized BCK 0->1 between consecutive clk cycles.
REQ-014 SHALL sample synchronized LRCK and DATA only on the clk cycle a BCK rise is detected; all other cycles hold state.
REQ-015 SHALL detect a slot boundary at a BCK rise whose sampled LRCK differs from the LRCK sampled at the previous BCK rise; the DATA bit on that rise belongs to the ending slot and is discarded.
REQ-016 SHALL, on following BCK rises, shift in bits MSB first; a bit counter saturates at DATA_W, bits beyond DATA_W are ignored, and a short slot is zero-padded in the LSBs.
REQ-017 SHALL use state machine HUNT -> LEFT -> RIGHT -> LEFT ...; HUNT leaves only on an LRCK 1->0 boundary (enter LEFT); LEFT->RIGHT on 0->1 boundary; RIGHT->LEFT on 1->0 boundary.
REQ-018 SHALL, on LEFT->RIGHT, latch the shift register into an internal left holding register.
REQ-019 SHALL, on RIGHT->LEFT, update l_chan_o from the holding register and r_chan_o from the shift register simultaneously, and assert valid_o on the next clk cycle for exactly one cycle.
REQ-020 SHALL set locked_o at the first valid_o pulse after HUNT and clear it on entry to HUNT.
REQ-021 SHALL hold l_chan_o/r_chan_o stable between valid_o pulses.
REQ-022 SHALL require BCK high and low phases of at least 2 clk cycles each; faster BCK is out of contract.

Reset
REQ-023 SHALL, while rst is high, set state HUNT, synchronizers, shift register, holding register, bit counter and timeout counter to 0, l_chan_o = 0, r_chan_o = 0, valid_o = 0, locked_o = 0.
REQ-024 SHALL discard any partial frame when rst asserts mid-slot; decoding restarts from HUNT.

Configuration
REQ-025 SHALL, with AURA_I2S_LOSS_DETECT_EN defined, count clk cycles since the last BCK rise; on reaching TIMEOUT_CYCLES go to HUNT, clear locked_o, and set l_chan_o/r_chan_o to 0 without a valid_o pulse.
REQ-026 SHALL, without AURA_I2S_LOSS_DETECT_EN, omit the timeout counter; outputs and state hold indefinitely when BCK stops.

Structure
REQ-027 SHALL place the DATA_W default constant and the state enum (HUNT, LEFT, RIGHT) in shared package aura_audio_pkg.
REQ-028 SHALL implement synchronization and edge detection in one sub-module, i2s_sync_edge, instantiated once per I2S input.

Verification
REQ-029 SHALL cover: BCK = clk/8, 16-bit frames L=16'h1234, R=16'hABCD -> one valid_o pulse per frame with l_chan_o=16'h1234, r_chan_o=16'hABCD; locked_o high after the first frame.
REQ-030 SHALL cover: stream started mid-right-slot -> no valid_o until the first complete LEFT+RIGHT pair; the partial data never appears.
REQ-031 SHALL cover: 24-bit slots L=24'h7FFF00, R=24'h800001 -> l_chan_o=16'h7FFF, r_chan_o=16'h8000; 12-bit slot R=12'hABC -> r_chan_o=16'hABC0.
REQ-032 SHALL cover: rst for 1 cycle mid-left-slot -> all outputs 0 at once; the next full frame decodes correctly.
REQ-033 SHALL cover, with AURA_I2S_LOSS_DETECT_EN: BCK stopped 1024 cycles -> locked_o=0, samples=0, no valid_o; without the macro, BCK stopped 5000 cycles -> outputs and locked_o unchanged.
